btn_mode_sequencer: RTL

Clocked, parametrised successor to the combinational button-to-operation selector.
- Synchronises and debounces the five board push-buttons.
- Converts debounced button activity into a registered operation mode (opr_mode_t from types_pkg).
- Computes the selected operation on the switch word in a registered datapath that drives the LEDs.
- Sits between the board pins and the LED bank at top level.

---
 rtl/btn_mode_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/btn_mode_sequencer.sv
// Button-driven operation sequencer: 2-flop sync, per-button debounce, registered mode and LED datapath.
// Define BTN_MODE_STICKY_EN for sticky (rise-selected) modes; default build is momentary (level-selected).
package types_pkg;
    typedef enum logic [2:0] {
        RESET        = 3'd0,
        ADD          = 3'd1,
        SUB          = 3'd2,
        MUL          = 3'd3,
        COUNT_ONES   = 3'd4,
        LEADING_ONES = 3'd5
    } opr_mode_t;
endpackage

module btn_mode_sequencer
    import types_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW,
    input  logic             BTNC,
    input  logic             BTNU,
    input  logic             BTND,
    input  logic             BTNL,
    input  logic             BTNR,
    output logic [WIDTH-1:0] LED,
    output opr_mode_t        MODE,
    output logic             MODE_STB
);

    localparam int HALF = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order {C, U, D, L, R}: index 4 carries the highest priority.
    logic [4:0]       btn_raw;
    logic [4:0]       btn_s1_q, btn_s2_q;
    logic [4:0]       db_q, db_dly_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic [4:0]       sel;
    opr_mode_t        mode_d, mode_q;
    logic             stb_q;
    logic [WIDTH-1:0] led_d, led_q;

    assign btn_raw = {BTNC, BTNU, BTND, BTNL, BTNR};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            db_dly_q <= db_q;
            for (int unsigned i = 0; i < 5; i++) begin
                if (btn_s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_q[i]  <= btn_s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_MODE_STICKY_EN
    assign sel = db_q & ~db_dly_q;
`else
    assign sel = db_q;
`endif

    always_comb begin
`ifdef BTN_MODE_STICKY_EN
        mode_d = mode_q;
`else
        mode_d = RESET;
`endif
        if (sel[4])      mode_d = MUL;
        else if (sel[3]) mode_d = LEADING_ONES;
        else if (sel[2]) mode_d = COUNT_ONES;
        else if (sel[1]) mode_d = ADD;
        else if (sel[0]) mode_d = SUB;
    end

    logic [HALF-1:0]  opa, opb;
    logic [WIDTH-1:0] ones_cnt, lead_cnt;
    logic             lead_run;

    assign opa = sw_s2_q[HALF-1:0];
    assign opb = sw_s2_q[WIDTH-1:HALF];

    // Leading-ones count: lead_run drops at the first 0 scanning down from the MSB.
    always_comb begin
        ones_cnt = '0;
        lead_cnt = '0;
        lead_run = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + WIDTH'(sw_s2_q[i]);
            lead_run = lead_run & sw_s2_q[WIDTH-1-i];
            lead_cnt = lead_cnt + WIDTH'(lead_run);
        end
        case (mode_q)
            ADD:          led_d = WIDTH'(opa) + WIDTH'(opb);
            SUB:          led_d = WIDTH'(opa) - WIDTH'(opb);
            MUL:          led_d = WIDTH'(opa) * WIDTH'(opb);
            COUNT_ONES:   led_d = ones_cnt;
            LEADING_ONES: led_d = lead_cnt;
            default:      led_d = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            mode_q <= RESET;
            stb_q  <= 1'b0;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            stb_q  <= (mode_d != mode_q);
            led_q  <= led_d;
        end
    end

    assign LED      = led_q;
    assign MODE     = mode_q;
    assign MODE_STB = stb_q;

endmodule
